// File: rtl/spi_pico_pkg.sv
// rtl/spi_pico_pkg.sv - shared constants for the PicoRV32 SPI slave
// Register offsets, STATUS bit positions and SPI mode constants used by
// spi_slave_pico and its RX buffer.
package spi_pico_pkg;

  // Register offsets relative to the peripheral base address
  localparam logic [31:0] REG_DATA_OFS   = 32'h0;
  localparam logic [31:0] REG_STATUS_OFS = 32'h4;

  // STATUS register bit positions
  localparam int STAT_RX_EMPTY  = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERRUN  = 3;
  localparam int STAT_BUSY      = 4;
  localparam int STAT_COUNT_LSB = 8;

  // SPI mode 0: clock idles low, data sampled on the leading (rising) edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_slave_rx_fifo.sv
// rtl/spi_slave_rx_fifo.sv - synchronous RX byte FIFO for the SPI slave
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   push, din     write request and data (dropped when full unless popping)
//   pop, dout     read request (ignored when empty) and head-of-queue data
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module spi_slave_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);
  assign count = cnt;
  assign dout  = mem[rptr];

  // A pop frees a slot in the same cycle, so push-while-full succeeds
  // when paired with a pop and the count stays unchanged.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/spi_slave_pico.sv
// rtl/spi_slave_pico.sv - memory-mapped SPI mode-0 slave for the PicoRV32 bus
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   addr, wen, wdata,         bus request: address, write strobe, write byte,
//   mem_valid                 request valid
//   rdata, spi_slave_ready    registered read data and one-cycle acknowledge
//   spi_slave_rx_int_flag     one-cycle pulse per received byte
//   SPI_Clk, SPI_CS_n,        asynchronous SPI pins from the master
//   SPI_MOSI
//   SPI_MISO                  serial data back to the master
// Registers: DATA at ADDR (read pops RX, write loads TX), STATUS at ADDR+4.
// Build option: define SPI_SLAVE_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO;
// otherwise a single holding register buffers received bytes.
module spi_slave_pico
  import spi_pico_pkg::*;
#(
  parameter logic [31:0] ADDR     = 32'hcaca_bec0,
  parameter int          RX_DEPTH = 4,
  parameter logic [7:0]  TX_IDLE  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [7:0]  wdata,
  input  logic        mem_valid,
  output logic [31:0] rdata,
  output logic        spi_slave_ready,
  output logic        spi_slave_rx_int_flag,
  input  logic        SPI_Clk,
  input  logic        SPI_CS_n,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO
);

  localparam int   CW             = $clog2(RX_DEPTH) + 1;
  localparam logic SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  // Synchronizers plus one history flop per SPI input
  logic sck_s1, sck_s2, sck_h;
  logic cs_s1, cs_s2, cs_h;
  logic mosi_s1, mosi_s2, mosi_h;

  logic       sck_rise, sck_fall, samp_edge, shift_edge;
  logic       cs_fall, cs_low;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, tx_hold;
  logic       tx_pending, underrun, overflow;
  logic       push, tx_load;
  logic [7:0] rx_byte;

  // Bus decode
  logic sel_data, sel_status, req;
  logic rd_data, wr_data, rd_status, wr_status;

  // RX buffer view
  logic [7:0]    rx_head;
  logic          rx_empty, rx_full;
  logic [CW-1:0] rx_cnt;
  logic [31:0]   status_word;

  assign sck_rise   = sck_s2 & ~sck_h;
  assign sck_fall   = ~sck_s2 & sck_h;
  assign samp_edge  = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_edge = SAMPLE_ON_RISE ? sck_fall : sck_rise;
  assign cs_fall    = ~cs_s2 & cs_h;
  assign cs_low     = ~cs_s2;

  // mosi_h is the sample taken just before the detected clock edge, so it
  // is the data the master set up during the preceding half period.
  assign rx_byte = {rx_shift[6:0], mosi_h};
  assign push    = cs_low & ~cs_fall & samp_edge & (bit_cnt == 3'd7);
  assign tx_load = cs_fall | push;

  assign SPI_MISO = tx_shift[7];

  assign sel_data   = (addr == ADDR + REG_DATA_OFS);
  assign sel_status = (addr == ADDR + REG_STATUS_OFS);
  assign req        = mem_valid & (sel_data | sel_status) & ~spi_slave_ready;
  assign rd_data    = req & sel_data & ~wen;
  assign wr_data    = req & sel_data & wen;
  assign rd_status  = req & sel_status & ~wen;
  assign wr_status  = req & sel_status & wen;

`ifdef SPI_SLAVE_RX_FIFO_EN
  spi_slave_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_byte),
    .pop   (rd_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );
`else
  logic       rx_valid;
  logic [7:0] rx_hold;

  // A push in the same cycle as a read replaces the byte being read out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_hold  <= 8'h00;
    end else if (push && (!rx_valid || rd_data)) begin
      rx_valid <= 1'b1;
      rx_hold  <= rx_byte;
    end else if (rd_data) begin
      rx_valid <= 1'b0;
    end
  end

  assign rx_head  = rx_hold;
  assign rx_empty = ~rx_valid;
  assign rx_full  = rx_valid;
  assign rx_cnt   = CW'(rx_valid);
`endif

  always_comb begin
    status_word                            = 32'h0;
    status_word[STAT_RX_EMPTY]             = rx_empty;
    status_word[STAT_RX_FULL]              = rx_full;
    status_word[STAT_OVERFLOW]             = overflow;
    status_word[STAT_UNDERRUN]             = underrun;
    status_word[STAT_BUSY]                 = cs_low;
    status_word[STAT_COUNT_LSB +: 8]       = 8'(rx_cnt);
  end

  // SPI side: synchronizers, deframing and TX shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_h <= 1'b0;
      cs_s1 <= 1'b1; cs_s2 <= 1'b1; cs_h <= 1'b1;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0; mosi_h <= 1'b0;
      bit_cnt               <= 3'd0;
      rx_shift              <= 8'h00;
      tx_shift              <= TX_IDLE;
      tx_hold               <= 8'h00;
      tx_pending            <= 1'b0;
      underrun              <= 1'b0;
      spi_slave_rx_int_flag <= 1'b0;
    end else begin
      sck_s1 <= SPI_Clk;   sck_s2 <= sck_s1;   sck_h <= sck_s2;
      cs_s1 <= SPI_CS_n;   cs_s2 <= cs_s1;     cs_h <= cs_s2;
      mosi_s1 <= SPI_MOSI; mosi_s2 <= mosi_s1; mosi_h <= mosi_s2;

      spi_slave_rx_int_flag <= push;

      if (!cs_low || cs_fall) begin
        bit_cnt <= 3'd0;
      end else if (samp_edge) begin
        rx_shift <= rx_byte;
        bit_cnt  <= bit_cnt + 3'd1;
      end

      // The trailing clock edge right after a completed byte (bit_cnt
      // back at 0) must not shift, or the freshly loaded MSB would be lost.
      if (tx_load) begin
        tx_shift <= tx_pending ? tx_hold : TX_IDLE;
      end else if (cs_low && shift_edge && bit_cnt != 3'd0) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // A CPU write in the same cycle as a load stays pending for the next byte
      if (wr_data) begin
        tx_hold    <= wdata;
        tx_pending <= 1'b1;
      end else if (tx_load) begin
        tx_pending <= 1'b0;
      end

      if (tx_load && !tx_pending) underrun <= 1'b1;
      else if (wr_status && wdata[STAT_UNDERRUN]) underrun <= 1'b0;
    end
  end

  // Bus side: registered acknowledge and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_slave_ready <= 1'b0;
      rdata           <= 32'h0;
      overflow        <= 1'b0;
    end else begin
      spi_slave_ready <= req;
      if (rd_data)        rdata <= {24'h0, rx_empty ? 8'h00 : rx_head};
      else if (rd_status) rdata <= status_word;
      else                rdata <= 32'h0;

      if (push && rx_full && !rd_data) overflow <= 1'b1;
      else if (wr_status && wdata[STAT_OVERFLOW]) overflow <= 1'b0;
    end
  end

endmodule
